scan_sequencer: RTL

- Top-level line scheduler for a film scan.
- For each of N lines it:
  - waits for space in the USB TX path,
  - requests one CCD line capture from the CCD timing block,
  - advances the film by a programmed number of motor steps,
  - waits a mechanical settle time.
- Sits between the control block (configuration, start/abort) and the CCD timing and stepper datapaths. It owns the line-capture trigger, the step pulses and the motor enable.

---
 rtl/scan_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// Film-scan line scheduler: per line, wait for USB TX space, capture one CCD line,
// step the film motor, settle. Owns the line trigger, step pulses and motor enable.
module scan_sequencer #(
    parameter int CAPTURE_TIMEOUT = 2000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk_100M,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_lines,
    input  logic [7:0]       steps_per_line,
    input  logic [CNT_W-1:0] step_half,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic             tx_ready,
    output logic             ccd_line_req,
    input  logic             ccd_line_done,
    input  logic             mtr_nflt,
    output logic             mtr_en,
    output logic             mtr_step,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] line_count
);
    localparam int TOW = $clog2(CAPTURE_TIMEOUT + 1);
    localparam int TW  = (TOW > CNT_W) ? TOW : CNT_W;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, WAIT_TX, CAPTURE, STEP_HI, STEP_LO, SETTLE, DONE, FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cfg_lines, cfg_half, cfg_settle;
    logic [7:0]       cfg_steps, step_cnt;
    logic [TW-1:0]    cnt;
    logic [1:0]       nflt_sync;
    logic             flt, active, line_ok;
    logic [CNT_W-1:0] half_last, settle_last;

    assign flt         = ~nflt_sync[1];
    // A zero half-period or settle time still takes one cycle.
    assign half_last   = (cfg_half == '0) ? '0 : cfg_half - ONE;
    assign settle_last = (cfg_settle == '0) ? '0 : cfg_settle - ONE;
    assign active      = (state != IDLE) && (state != FAULT);
    assign busy        = active;
    assign mtr_en      = active;
    assign mtr_step    = (state == STEP_HI) && !flt;
    assign line_ok     = (state == CAPTURE) && ccd_line_done && !abort && !flt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (n_lines == '0) ? DONE : WAIT_TX;
            WAIT_TX: if (tx_ready) state_nxt = CAPTURE;
            CAPTURE: begin
                if (ccd_line_done) begin
                    if (line_count + ONE == cfg_lines) state_nxt = DONE;
                    else if (cfg_steps == 8'd0)        state_nxt = SETTLE;
                    else                               state_nxt = STEP_HI;
                end else if (cnt == TW'(CAPTURE_TIMEOUT)) begin
                    state_nxt = FAULT;
                end
            end
            STEP_HI: if (cnt == TW'(half_last)) state_nxt = STEP_LO;
            STEP_LO: if (cnt == TW'(half_last)) state_nxt = (step_cnt == 8'd1) ? SETTLE : STEP_HI;
            SETTLE:  if (cnt == TW'(settle_last)) state_nxt = WAIT_TX;
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Fault beats abort beats the normal transition.
        if (state != IDLE && abort) state_nxt = IDLE;
        if (active && flt) state_nxt = FAULT;
    end

    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) nflt_sync <= 2'b11;
        else       nflt_sync <= {nflt_sync[0], mtr_nflt};
    end

    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            cnt          <= '0;
            cfg_lines    <= '0;
            cfg_half     <= '0;
            cfg_settle   <= '0;
            cfg_steps    <= '0;
            step_cnt     <= '0;
            line_count   <= '0;
            error        <= 1'b0;
            ccd_line_req <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= (state_nxt != state) ? '0 : cnt + TW'(1);
            ccd_line_req <= (state == WAIT_TX) && (state_nxt == CAPTURE);
            done         <= (state == DONE) && (state_nxt == IDLE) && !abort;
            if (state == IDLE && start) begin
                cfg_lines  <= n_lines;
                cfg_half   <= step_half;
                cfg_settle <= settle_cycles;
                cfg_steps  <= steps_per_line;
                line_count <= '0;
                error      <= 1'b0;
            end
            if (line_ok) line_count <= line_count + ONE;
            if (state == CAPTURE && state_nxt == STEP_HI)
                step_cnt <= cfg_steps;
            else if (state == STEP_LO && (state_nxt == STEP_HI || state_nxt == SETTLE))
                step_cnt <= step_cnt - 8'd1;
            if (state_nxt == FAULT) error <= 1'b1;
        end
    end
endmodule
